// File: rtl/if_stage_if.sv
// if_stage_if: bus bundle between the instruction-fetch stage and its
// neighbours. It carries the hazard/branch control inputs, the
// instruction-memory address and read data, and the IF/ID register outputs.
// The slave modport is the fetch stage; the master modport is whatever
// surrounds it (pipeline top or testbench).
interface if_stage_if;
  logic        PCWrite_i;
  logic        Stall_i;
  logic        Flush_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_instr_i;
  logic [31:0] pc_o;
  logic [31:0] IFID_pc_o;
  logic [31:0] IFID_instr_o;
  logic        IFID_valid_o;
  logic        running_o;

  modport slave (
    input  PCWrite_i, Stall_i, Flush_i, branch_target_i, imem_instr_i,
    output pc_o, IFID_pc_o, IFID_instr_o, IFID_valid_o, running_o
  );

  modport master (
    output PCWrite_i, Stall_i, Flush_i, branch_target_i, imem_instr_i,
    input  pc_o, IFID_pc_o, IFID_instr_o, IFID_valid_o, running_o
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage RISC-V pipeline.
// It owns the PC and the IF/ID register, and it has a start gate that holds
// the stage idle until start_i is seen.
// Optional macro IF_STAGE_PERF_EN adds saturating fetch/stall/flush counters.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | PC is parked at RESET_PC and IF/ID holds a bubble; hazard inputs are ignored
// RUN    | fetching; it leaves RUN only through reset
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  if_stage_if.slave   bus
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        run_w;

  assign run_w = (state_q == S_RUN);

  // Next-state for the start gate, the PC and IF/ID. Flush beats both
  // PCWrite and Stall, so a resolved branch always wins.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (!run_w) begin
      if (start_i) state_d = S_RUN;
      pc_d         = RESET_PC;
      ifid_pc_d    = 32'h0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else begin
      if (bus.Flush_i)        pc_d = bus.branch_target_i;
      else if (bus.PCWrite_i) pc_d = pc_q + 32'(PC_STEP);

      if (bus.Flush_i) begin
        ifid_pc_d    = 32'h0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end else if (!bus.Stall_i) begin
        ifid_pc_d    = pc_q;
        ifid_instr_d = bus.imem_instr_i;
        ifid_valid_d = 1'b1;
      end
    end
  end

  // State registers; reset overrides every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.IFID_pc_o    = ifid_pc_q;
  assign bus.IFID_instr_o = ifid_instr_q;
  assign bus.IFID_valid_o = ifid_valid_q;
  assign bus.running_o    = run_w;

`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters, active only in RUN.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (run_w) begin
      if (!bus.Flush_i && !bus.Stall_i && fetch_cnt_q != 32'hFFFF_FFFF)
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (!bus.Flush_i && bus.Stall_i && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_d = stall_cnt_q + 32'd1;
      if (bus.Flush_i && flush_cnt_q != 32'hFFFF_FFFF)
        flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed-vector bench for if_stage. Each vector sets the inputs
// for one rising edge and carries the hand-computed register contents that
// must follow that edge. The stimulus process queues the expectation. The
// monitor process pops it after the edge and compares it with the DUT outputs.
module tb_if_stage;
  logic clk;
  logic rst;
  logic start;

  if_stage_if bus();

  if_stage dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: every word identifies its own address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign bus.imem_instr_i = mem(bus.pc_o);

  typedef struct {
    logic        rst, start, pcw, stall, flush;
    logic [31:0] tgt;
    logic [31:0] pc, ifpc;
    logic        v, run;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc, ifpc, instr;
    logic        v, run;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic s, input logic pw, input logic st,
                     input logic fl, input logic [31:0] tg, input logic [31:0] pc,
                     input logic [31:0] ifpc, input logic v, input logic run);
    vec_t e;
    e.rst = r; e.start = s; e.pcw = pw; e.stall = st; e.flush = fl; e.tgt = tg;
    e.pc = pc; e.ifpc = ifpc; e.v = v; e.run = run;
    vecs.push_back(e);
  endtask

  // Monitor: one comparison per edge that has a queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (bus.pc_o !== x.pc || bus.IFID_pc_o !== x.ifpc ||
            bus.IFID_instr_o !== x.instr || bus.IFID_valid_o !== x.v ||
            bus.running_o !== x.run) begin
          errors++;
          $display("FAIL vec%0d: got pc=%h ifpc=%h instr=%h v=%b run=%b, want pc=%h ifpc=%h instr=%h v=%b run=%b",
                   x.idx, bus.pc_o, bus.IFID_pc_o, bus.IFID_instr_o, bus.IFID_valid_o,
                   bus.running_o, x.pc, x.ifpc, x.instr, x.v, x.run);
        end
      end
    end
  end

  initial begin
    exp_t x;
    int   waited;
    rst = 1'b1; start = 1'b0;
    bus.PCWrite_i = 1'b1; bus.Stall_i = 1'b0; bus.Flush_i = 1'b0;
    bus.branch_target_i = 32'h0;

    //   rst start pcw stall flush target         pc             ifid_pc        v  run
    add(1, 0, 1, 0, 0, 32'h0,          32'h0,         32'h0,         0, 0);
    add(1, 0, 1, 0, 0, 32'h0,          32'h0,         32'h0,         0, 0);
    add(0, 0, 1, 0, 0, 32'h0,          32'h0,         32'h0,         0, 0);
    add(0, 0, 0, 1, 1, 32'h55,         32'h0,         32'h0,         0, 0); // ignored in IDLE
    add(0, 0, 1, 0, 0, 32'h0,          32'h0,         32'h0,         0, 0);
    add(0, 1, 1, 0, 0, 32'h0,          32'h0,         32'h0,         0, 1); // enter RUN
    add(0, 0, 1, 0, 0, 32'h0,          32'h4,         32'h0,         1, 1);
    add(0, 0, 1, 0, 0, 32'h0,          32'h8,         32'h4,         1, 1);
    add(0, 0, 1, 0, 0, 32'h0,          32'hC,         32'h8,         1, 1);
    add(0, 0, 1, 0, 0, 32'h0,          32'h10,        32'hC,         1, 1);
    add(0, 0, 0, 1, 0, 32'h0,          32'h10,        32'hC,         1, 1); // load-use stall
    add(0, 0, 1, 0, 0, 32'h0,          32'h14,        32'h10,        1, 1);
    add(0, 0, 1, 0, 0, 32'h0,          32'h18,        32'h14,        1, 1);
    add(0, 0, 1, 0, 1, 32'h40,         32'h40,        32'h0,         0, 1); // branch flush
    add(0, 0, 1, 0, 0, 32'h0,          32'h44,        32'h40,        1, 1);
    add(0, 0, 0, 1, 1, 32'h80,         32'h80,        32'h0,         0, 1); // flush beats stall
    add(0, 0, 1, 0, 1, 32'h100,        32'h100,       32'h0,         0, 1); // back-to-back flush
    add(0, 0, 1, 0, 1, 32'h200,        32'h200,       32'h0,         0, 1);
    add(0, 0, 1, 0, 0, 32'h0,          32'h204,       32'h200,       1, 1);
    add(0, 0, 1, 1, 0, 32'h0,          32'h208,       32'h200,       1, 1); // stall with PCWrite=1
    add(0, 0, 0, 1, 0, 32'h0,          32'h208,       32'h200,       1, 1); // consecutive stall
    add(0, 0, 0, 1, 0, 32'h0,          32'h208,       32'h200,       1, 1);
    add(0, 0, 0, 0, 0, 32'h0,          32'h208,       32'h208,       1, 1); // refetch same PC
    add(0, 0, 1, 0, 0, 32'h0,          32'h20C,       32'h208,       1, 1);
    add(0, 0, 1, 0, 1, 32'h302,        32'h302,       32'h0,         0, 1); // unaligned target verbatim
    add(0, 0, 0, 1, 0, 32'h0,          32'h302,       32'h0,         0, 1); // stall holds bubble
    add(0, 0, 1, 0, 0, 32'h0,          32'h306,       32'h302,       1, 1);
    add(0, 0, 1, 0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0,         0, 1);
    add(0, 0, 1, 0, 0, 32'h0,          32'h0,         32'hFFFF_FFFC, 1, 1); // wrap
    add(0, 1, 1, 0, 0, 32'h0,          32'h4,         32'h0,         1, 1); // start ignored in RUN
    add(0, 0, 0, 1, 0, 32'h0,          32'h4,         32'h0,         1, 1);
    add(1, 0, 1, 1, 1, 32'h999,        32'h0,         32'h0,         0, 0); // reset mid-stall/flush
    add(0, 0, 1, 0, 0, 32'h0,          32'h0,         32'h0,         0, 0);
    add(0, 1, 1, 0, 0, 32'h0,          32'h0,         32'h0,         0, 1);
    add(0, 0, 1, 0, 0, 32'h0,          32'h4,         32'h0,         1, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      start = vecs[i].start;
      bus.PCWrite_i = vecs[i].pcw;
      bus.Stall_i = vecs[i].stall;
      bus.Flush_i = vecs[i].flush;
      bus.branch_target_i = vecs[i].tgt;
      x.idx = i;
      x.pc = vecs[i].pc;
      x.ifpc = vecs[i].ifpc;
      x.v = vecs[i].v;
      x.run = vecs[i].run;
      x.instr = vecs[i].v ? mem(vecs[i].ifpc) : 32'h0000_0000;
      sb.push_back(x);
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Consumes PCWrite and the stall signal from the hazard detection unit, and the flush/branch target from the ID-stage branch logic.
- Drives the instruction-memory address and feeds the decode stage.
- Includes a start gate (IDLE/RUN state machine) and a bubble-valid flag so downstream stages can tell real instructions from inserted NOPs.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset and held while IDLE.
- NOP_INSTR, 32'h0000_0000, encoding written into IF/ID on reset or flush (bubble).
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  level; leaving IDLE requires start_i=1.
- PCWrite_i  in  1  from hazard unit; 0 = hold PC.
- Stall_i  in  1  from hazard unit; 1 = hold IF/ID contents.
- Flush_i  in  1  from ID branch logic; 1 = taken branch resolved in ID.
- branch_target_i  in  32  redirect address, valid when Flush_i=1.
- imem_instr_i  in  32  combinational instruction-memory read data for address pc_o.
- pc_o  out  32  current PC; instruction-memory address.
- IFID_pc_o  out  32  PC of the instruction held in IF/ID.
- IFID_instr_o  out  32  instruction held in IF/ID.
- IFID_valid_o  out  1  1 = IF/ID holds a real fetched instruction; 0 = bubble.
- running_o  out  1  1 when the FSM is in RUN.

Behaviour:
- Reset (rst_i=1 at an edge, from any state, including mid-stall or mid-flush):
  - pc_o=RESET_PC, IFID_pc_o=0, IFID_instr_o=NOP_INSTR, IFID_valid_o=0.
  - FSM=IDLE, running_o=0.
  - Reset overrides every other input.
- FSM has two states:
  - IDLE -> RUN on an edge with start_i=1.
  - RUN stays RUN until reset; start_i is ignored in RUN.
- IDLE:
  - PC holds RESET_PC.
  - IF/ID holds NOP_INSTR with valid=0.
  - PCWrite_i, Stall_i, Flush_i and branch_target_i are ignored.
- First RUN cycle: pc_o=RESET_PC is presented to memory; the first valid IF/ID entry appears one edge later. Fetch latency is 1 cycle from PC to IF/ID.
- PC update in RUN, priority high to low:
  - Flush_i=1 -> PC <= branch_target_i. Flush overrides PCWrite_i=0.
  - PCWrite_i=0 -> PC holds.
  - Otherwise PC <= pc_o + PC_STEP.
  - Arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. No alignment checking; branch_target_i is loaded verbatim.
- IF/ID update in RUN, priority high to low:
  - Flush_i=1 -> instr=NOP_INSTR, pc=0, valid=0. Flush wins over Stall_i.
  - Stall_i=1 -> all IF/ID fields hold, including valid.
  - Otherwise instr=imem_instr_i, pc=pc_o, valid=1.
- Mismatched hazard inputs:
  - Stall_i=1 with PCWrite_i=1 is legal. PC advances and the fetched word is dropped; the hazard unit never drives this, but the block must not corrupt IF/ID.
  - PCWrite_i=0 with Stall_i=0 re-fetches the same PC into IF/ID. This is legal.
- Back-to-back flushes: each flush reloads the PC and re-bubbles IF/ID; no flush is lost.
- Stall in consecutive cycles: IF/ID and PC hold for the full duration with no drift.
- All outputs are registered except running_o, which is decoded from the state register.

Optional Feature:
- Macro: IF_STAGE_PERF_EN.
- When defined, the block adds outputs fetch_cnt_o[31:0], stall_cnt_o[31:0] and flush_cnt_o[31:0]. All are cleared on reset and count only in RUN:
  - fetch_cnt_o: increments on every edge that loads a valid instruction into IF/ID.
  - stall_cnt_o: increments on every edge with Stall_i=1 and Flush_i=0.
  - flush_cnt_o: increments on every edge with Flush_i=1.
  - Counters saturate at 32'hFFFF_FFFF.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then start: rst_i=1 for 2 cycles, start_i=0 for 3 cycles -> pc_o=0, IFID_valid_o=0, running_o=0 throughout. Then start_i=1 -> after 1 edge running_o=1; after 2 edges IFID_pc_o=0, valid=1; pc_o steps 4, 8, 12.
- Load-use stall: at pc_o=0x10, drive PCWrite_i=0 and Stall_i=1 for 1 cycle -> pc_o stays 0x10 and IFID_pc_o stays 0x0C for that edge; next edge resumes with IFID_pc_o=0x10.
- Branch flush: Flush_i=1, branch_target_i=0x40 at pc_o=0x18 -> next edge pc_o=0x40, IFID_instr_o=NOP_INSTR, valid=0; following edge IFID_pc_o=0x40, valid=1.
- Flush and stall together: Flush_i=1, Stall_i=1, PCWrite_i=0, target 0x80 -> pc_o=0x80, IF/ID bubbled; flush wins.
- Wrap and reset mid-stall: flush to 0xFFFF_FFFC, then run -> pc_o=0 next. Then hold Stall_i=1 and assert rst_i -> all outputs return to reset values and FSM=IDLE.
- With IF_STAGE_PERF_EN: 5 fetches, 2 stall cycles, 1 flush -> fetch_cnt_o=5, stall_cnt_o=2, flush_cnt_o=1.
